fmap_buffer: RTL and testbench

FMAP_BUFFER -- requirements
Module: fmap_buffer

---
 rtl/fmap_buffer_pkg.sv | 24 ++
 rtl/fmap_bank_ram.sv | 29 ++
 rtl/fmap_buffer.sv | 227 ++++++++++++++++++++++
 tb/tb_fmap_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fmap_buffer_pkg.sv
// Shared types and constants for the fmap_buffer ping-pong feature-map buffer.
package fmap_buffer_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    localparam int DEFAULT_DIM   = 14;
    localparam int DEFAULT_W     = 9;
    localparam int DEFAULT_FRAME = DEFAULT_DIM * DEFAULT_DIM;

    function automatic int frame_size(input int dim);
        return dim * dim;
    endfunction

    // Counter width that never collapses to zero bits for tiny sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_bank_ram.sv
// One frame bank: single write port, synchronous read port with a one-cycle latency.
module fmap_bank_ram
    import fmap_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FRAME,
    parameter int W     = DEFAULT_W,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [W-1:0] wdata,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic signed [W-1:0] rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fmap_buffer.sv
// Two-bank ping-pong buffer between a pooling layer and the next layer.
// Optional statistics outputs are enabled with `define FMAP_BUFFER_STATS_EN.
module fmap_buffer
    import fmap_buffer_pkg::*;
#(
    parameter int DIM = DEFAULT_DIM,
    parameter int W   = DEFAULT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    output logic signed [W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                out_row_end,
`ifdef FMAP_BUFFER_STATS_EN
    output logic [15:0]         frame_count,
    output logic [15:0]         drop_count,
`endif
    output logic                drop
);

    localparam int FRAME = frame_size(DIM);
    localparam int AW    = idx_width(FRAME);
    localparam int CW    = idx_width(DIM);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(DIM - 1);

    bank_state_e bank_state [2];

    logic          wr_bank;
    logic [AW-1:0] wr_idx;
    logic          stall;

    logic          rd_bank;
    logic [AW-1:0] rd_idx;
    logic [CW-1:0] rd_col;
    logic          rd_done;

    logic pend_valid, pend_last, pend_row_end, pend_bank;
    logic skid_valid, skid_last, skid_row_end;
    logic signed [W-1:0] skid_data;

    logic signed [W-1:0] ram_rdata [2];
    logic signed [W-1:0] pend_data;

    logic       wr_en, wr_last, xfer, frame_done, other_free;
    logic       rd_src_ok, rd_en, load_out;
    logic [1:0] occ;

    // Output handshake: a word moves when out_valid and out_ready are both high
    // at a rising edge; while out_valid is high and out_ready low, the word and
    // its flags hold, and out_valid never drops without a transfer.
    assign xfer       = out_valid && out_ready;
    assign frame_done = xfer && out_last;

    assign wr_en   = in_valid && !stall;
    assign wr_last = wr_en && (wr_idx == LAST_IDX);
    // A bank freed by the final transfer this cycle counts as free right away.
    assign other_free = (bank_state[~wr_bank] == BANK_EMPTY) ||
                        (frame_done && (rd_bank == ~wr_bank));

    assign rd_src_ok = (bank_state[rd_bank] == BANK_FULL) ||
                       ((bank_state[rd_bank] == BANK_DRAINING) && !rd_done);
    // Words already held or in flight after this edge; at most two fit.
    assign occ       = 2'(out_valid) + 2'(skid_valid) + 2'(pend_valid) - 2'(xfer);
    assign rd_en     = rd_src_ok && (occ < 2'd2);
    assign load_out  = !out_valid || xfer;

    assign pend_data = pend_bank ? ram_rdata[1] : ram_rdata[0];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fmap_bank_ram #(
            .DEPTH(FRAME),
            .W    (W),
            .AW   (AW)
        ) u_ram (
            .clk  (clk),
            .we   (wr_en && (wr_bank == 1'(g))),
            .waddr(wr_idx),
            .wdata(in_data),
            .re   (rd_en && (rd_bank == 1'(g))),
            .raddr(rd_idx),
            .rdata(ram_rdata[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (frame_done && (rd_bank == i[0])) begin
                    bank_state[i] <= BANK_EMPTY;
                end else if (rd_en && (rd_bank == i[0]) && (bank_state[i] == BANK_FULL)) begin
                    bank_state[i] <= BANK_DRAINING;
                end else if (wr_last && (wr_bank == i[0])) begin
                    bank_state[i] <= BANK_FULL;
                end else if (wr_en && (wr_bank == i[0]) && (bank_state[i] == BANK_EMPTY)) begin
                    bank_state[i] <= BANK_FILLING;
                end
            end
        end
    end

    // Writer: after a frame it always points at the other bank, stalling until
    // that bank has been drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            stall   <= 1'b0;
            drop    <= 1'b0;
        end else begin
            drop <= stall && in_valid;
            if (stall) begin
                if ((bank_state[wr_bank] == BANK_EMPTY) ||
                    (frame_done && (rd_bank == wr_bank))) begin
                    stall <= 1'b0;
                end
            end else if (wr_en) begin
                if (wr_last) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                    stall   <= !other_free;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_bank      <= 1'b0;
            rd_idx       <= '0;
            rd_col       <= '0;
            rd_done      <= 1'b0;
            pend_valid   <= 1'b0;
            pend_last    <= 1'b0;
            pend_row_end <= 1'b0;
            pend_bank    <= 1'b0;
        end else begin
            pend_valid   <= rd_en;
            pend_last    <= (rd_idx == LAST_IDX);
            pend_row_end <= (rd_col == LAST_COL);
            pend_bank    <= rd_bank;
            if (rd_en) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx  <= '0;
                    rd_done <= 1'b1;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
                rd_col <= (rd_col == LAST_COL) ? '0 : rd_col + 1'b1;
            end
            if (frame_done) begin
                rd_bank <= ~rd_bank;
                rd_done <= 1'b0;
            end
        end
    end

    // Output register plus skid register: the skid catches the word already in
    // flight from the RAM when the downstream stage stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            out_row_end  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            skid_last    <= 1'b0;
            skid_row_end <= 1'b0;
        end else begin
            if (load_out) begin
                if (skid_valid) begin
                    out_valid   <= 1'b1;
                    out_data    <= skid_data;
                    out_last    <= skid_last;
                    out_row_end <= skid_row_end;
                end else if (pend_valid) begin
                    out_valid   <= 1'b1;
                    out_data    <= pend_data;
                    out_last    <= pend_last;
                    out_row_end <= pend_row_end;
                end else begin
                    out_valid   <= 1'b0;
                    out_last    <= 1'b0;
                    out_row_end <= 1'b0;
                end
            end
            if (load_out && skid_valid) begin
                skid_valid   <= pend_valid;
                skid_data    <= pend_data;
                skid_last    <= pend_last;
                skid_row_end <= pend_row_end;
            end else if (!load_out && pend_valid) begin
                skid_valid   <= 1'b1;
                skid_data    <= pend_data;
                skid_last    <= pend_last;
                skid_row_end <= pend_row_end;
            end
        end
    end

`ifdef FMAP_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (stall && in_valid && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fmap_buffer.sv
// Self-checking bench for fmap_buffer: scoreboard of expected output words.
module tb_fmap_buffer;

    localparam int DIM   = 14;
    localparam int W     = 9;
    localparam int FRAME = DIM * DIM;
    localparam int EW    = W + 2;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [W-1:0] in_data;
    logic                in_valid;
    logic signed [W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                out_row_end;
    logic                drop;
`ifdef FMAP_BUFFER_STATS_EN
    logic [15:0]         frame_count;
    logic [15:0]         drop_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int drop_seen = 0;
    logic [EW-1:0] exp_q[$];

    fmap_buffer #(.DIM(DIM), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_row_end(out_row_end),
`ifdef FMAP_BUFFER_STATS_EN
        .frame_count(frame_count),
        .drop_count (drop_count),
`endif
        .drop       (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected word for pixel value v: {last, row_end, data}.
    function automatic logic [EW-1:0] exp_word(input int v);
        int idx;
        logic [W-1:0] d;
        idx = (v - 1) % FRAME;
        d   = W'(v);
        return {(idx == FRAME - 1), ((idx % DIM) == DIM - 1), d};
    endfunction

    // Drives n back-to-back pixels first..first+n-1; pushes only values <= push_max.
    task automatic drive_pixels(input int first, input int n, input int push_max);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = W'(first + k);
            if (first + k <= push_max) exp_q.push_back(exp_word(first + k));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("out_data", 32'(out_data[W-1:0]), 32'(e[W-1:0]));
                check("out_last", 32'(out_last), 32'(e[W+1]));
                check("out_row_end", 32'(out_row_end), 32'(e[W]));
            end
        end
        if (reset && drop) drop_seen++;
    end

    initial begin
        int base;
        int n;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_row_end", 32'(out_row_end), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_out_data", 32'(out_data[W-1:0]), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Streaming frame and first-output latency.
        out_ready = 1'b1;
        drive_pixels(1, FRAME, FRAME);
        check("lat_e0_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_e1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_e2_valid", 32'(out_valid), 32'd1);
        check("lat_e2_data", 32'(out_data[W-1:0]), 32'd1);
        wait_drain(400);

        // Ping-pong: two frames back to back, no drops.
        base = drop_seen;
        drive_pixels(1, 2 * FRAME, 2 * FRAME);
        wait_drain(600);
        check("pingpong_drops", 32'(drop_seen - base), 32'd0);

        // Backpressure: third frame is dropped while both banks are held.
        out_ready = 1'b0;
        base = drop_seen;
        drive_pixels(1, 3 * FRAME, 2 * FRAME);
        repeat (2) @(posedge clk);
        #1;
        check("bp_drops", 32'(drop_seen - base), 32'd196);
`ifdef FMAP_BUFFER_STATS_EN
        check("bp_drop_count", 32'(drop_count), 32'd196);
`endif
        out_ready = 1'b1;
        wait_drain(1000);

        // Downstream stall at value 50.
        drive_pixels(1, FRAME, FRAME);
        n = 0;
        while (!(out_valid && out_data == W'(50)) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_reach50", 32'(out_data[W-1:0]), 32'd50);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("stall_hold_valid", 32'(out_valid), 32'd1);
            check("stall_hold_data", 32'(out_data[W-1:0]), 32'd50);
        end
        out_ready = 1'b1;
        wait_drain(400);

        // Random downstream readiness across two buffered frames.
        out_ready = 1'b0;
        drive_pixels(1, 2 * FRAME, 2 * FRAME);
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b1;
        wait_drain(100);

        // Reset mid-frame with a full bank waiting: everything is discarded.
        out_ready = 1'b0;
        drive_pixels(1, FRAME + 100, 0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("in_rst_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        drive_pixels(1, FRAME, FRAME);
        wait_drain(400);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
